// File: rtl/pipelined_addsub_if.sv
// pipelined_addsub_if: operand/result handshake bundle for pipelined_addsub.
// The producer/consumer side uses the master modport; the adder uses slave.
interface pipelined_addsub_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, result, carry, overflow, zero
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, result, carry, overflow, zero
    );
endinterface

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: two's-complement add/subtract over a carry chain cut into
// STAGES registered segments of SEG = WIDTH/STAGES bits each.
// Stage k adds segment k and registers it together with the carry, the
// finished low bits and the still-unprocessed high operand bits. The final
// stage also produces carry/borrow, signed overflow and zero.
// Optional feature: define ADDSUB_SAT_EN to saturate the result on signed
// overflow; left undefined, the result wraps modulo 2^WIDTH.
module pipelined_addsub #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input logic               clk,
    input logic               rst,
    pipelined_addsub_if.slave bus
);
    localparam int SEG = WIDTH / STAGES;
    localparam int MSB = WIDTH - 1;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_overflow;
    logic             r_zero;

    logic             w_adv;
    logic [WIDTH-1:0] w_b_eff;

    // Final-stage operands: either straight from the bus or from stage STAGES-2.
    logic [SEG-1:0]   w_fa;
    logic [SEG-1:0]   w_fb;
    logic             w_fcin;
    logic             w_fsub;
    logic             w_fvld;
    logic [SEG:0]     w_fseg;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    logic             w_carry;

    // Whole pipeline moves as one; a stalled output freezes every stage.
    assign w_adv        = ~r_out_valid | bus.out_ready;
    assign bus.in_ready = w_adv;
    assign w_b_eff      = bus.b ^ {WIDTH{bus.sub}};

    generate
        if ((STAGES < 1) || (WIDTH % STAGES != 0)) begin : g_bad_cfg
            $error("pipelined_addsub: WIDTH must be a multiple of STAGES");
        end

        if (STAGES == 1) begin : g_single
            assign w_fa   = bus.a;
            assign w_fb   = w_b_eff;
            assign w_fcin = bus.sub;
            assign w_fsub = bus.sub;
            assign w_fvld = bus.in_valid;
            assign w_sum  = w_fseg[SEG-1:0];
        end else begin : g_multi
            for (genvar j = 0; j < STAGES - 1; j++) begin : g_stage
                localparam int LO = (j + 1) * SEG;
                localparam int HI = WIDTH - LO;

                logic [LO-1:0] r_lo;
                logic [HI-1:0] r_a_hi;
                logic [HI-1:0] r_b_hi;
                logic          r_c;
                logic          r_sub;
                logic          r_vld;

                logic [SEG:0]  w_seg;
                logic [LO-1:0] w_lo_nxt;
                logic [HI-1:0] w_a_hi_nxt;
                logic [HI-1:0] w_b_hi_nxt;
                logic          w_sub_nxt;
                logic          w_vld_nxt;

                if (j == 0) begin : g_first
                    assign w_seg      = {1'b0, bus.a[SEG-1:0]} + {1'b0, w_b_eff[SEG-1:0]}
                                      + {{SEG{1'b0}}, bus.sub};
                    assign w_lo_nxt   = w_seg[SEG-1:0];
                    assign w_a_hi_nxt = bus.a[MSB:SEG];
                    assign w_b_hi_nxt = w_b_eff[MSB:SEG];
                    assign w_sub_nxt  = bus.sub;
                    assign w_vld_nxt  = bus.in_valid;
                end else begin : g_mid
                    assign w_seg      = {1'b0, g_stage[j-1].r_a_hi[SEG-1:0]}
                                      + {1'b0, g_stage[j-1].r_b_hi[SEG-1:0]}
                                      + {{SEG{1'b0}}, g_stage[j-1].r_c};
                    assign w_lo_nxt   = {w_seg[SEG-1:0], g_stage[j-1].r_lo};
                    assign w_a_hi_nxt = g_stage[j-1].r_a_hi[HI+SEG-1:SEG];
                    assign w_b_hi_nxt = g_stage[j-1].r_b_hi[HI+SEG-1:SEG];
                    assign w_sub_nxt  = g_stage[j-1].r_sub;
                    assign w_vld_nxt  = g_stage[j-1].r_vld;
                end

                // Segment register: captures this stage's partial sum, holds on stall.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_lo   <= '0;
                        r_a_hi <= '0;
                        r_b_hi <= '0;
                        r_c    <= 1'b0;
                        r_sub  <= 1'b0;
                        r_vld  <= 1'b0;
                    end else if (w_adv) begin
                        r_lo   <= w_lo_nxt;
                        r_a_hi <= w_a_hi_nxt;
                        r_b_hi <= w_b_hi_nxt;
                        r_c    <= w_seg[SEG];
                        r_sub  <= w_sub_nxt;
                        r_vld  <= w_vld_nxt;
                    end
                end
            end

            assign w_fa   = g_stage[STAGES-2].r_a_hi;
            assign w_fb   = g_stage[STAGES-2].r_b_hi;
            assign w_fcin = g_stage[STAGES-2].r_c;
            assign w_fsub = g_stage[STAGES-2].r_sub;
            assign w_fvld = g_stage[STAGES-2].r_vld;
            assign w_sum  = {w_fseg[SEG-1:0], g_stage[STAGES-2].r_lo};
        end
    endgenerate

    assign w_fseg  = {1'b0, w_fa} + {1'b0, w_fb} + {{SEG{1'b0}}, w_fcin};
    // Operand MSBs live at the top of the last segment; b is already inverted for sub.
    assign w_ovf   = (w_fa[SEG-1] == w_fb[SEG-1]) & (w_sum[MSB] != w_fa[SEG-1]);
    assign w_carry = w_fseg[SEG] ^ w_fsub;

`ifdef ADDSUB_SAT_EN
    // Clamp toward the sign of a when the signed result has wrapped.
    assign w_res = w_ovf ? (w_fa[SEG-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                        : {1'b0, {(WIDTH-1){1'b1}}})
                         : w_sum;
`else
    assign w_res = w_sum;
`endif

    // Output register: result and flags of the final stage, frozen while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_carry     <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= w_fvld;
            r_result    <= w_res;
            r_carry     <= w_carry;
            r_overflow  <= w_ovf;
            r_zero      <= ~|w_res;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.carry     = r_carry;
    assign bus.overflow  = r_overflow;
    assign bus.zero      = r_zero;
endmodule
